// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: decodes funct3, drives a req/ack data-memory port,
// stalls the core for the access and returns extended load data plus a fault code.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         err_d;
    logic [31:0]        rdata_d, addr_d, wdata_d;
    logic [3:0]         be_d;
    logic               we_d;
    logic               stall_c;

    logic               is_load, is_store, mem_op, legal, misaligned;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;

    assign is_load  = (i_opcode == OP_LOAD);
    assign is_store = (i_opcode == OP_STORE);
    assign mem_op   = i_valid && (is_load || is_store);

    // funct3 legality and alignment of the presented instruction
    always_comb begin
        legal = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = is_load;
            default:                legal = 1'b0;
        endcase
        misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    end

    // Store lane steering; loads request no byte enables
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << i_addr[1:0];
                st_wdata = {2{i_wdata[15:0]}};
            end
            default: st_be = 4'b1111;
        endcase
        if (!is_store) st_be = 4'b0000;
    end

    assign ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = i_mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        err_d   = o_err;
        rdata_d = o_rdata;
        we_d    = o_mem_we;
        addr_d  = o_mem_addr;
        wdata_d = o_mem_wdata;
        be_d    = o_mem_be;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_c = 1'b1;
                    if (!legal) begin
                        err_d   = ERR_ILL;
                        state_d = DONE;
                    end else if (misaligned) begin
                        err_d   = ERR_MIS;
                        state_d = DONE;
                    end else begin
                        we_d    = is_store;
                        addr_d  = {i_addr[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        f3_d    = i_funct3;
                        off_d   = i_addr[1:0];
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (i_mem_ack) begin
                    if (!o_mem_we) rdata_d = ld_ext;
                    err_d   = ERR_NONE;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = ERR_TO;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the stall so the core is released the moment reset hits
    assign o_stall = stall_c && !i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            o_done      <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_err       <= '0;
            o_mem_be    <= '0;
            o_rdata     <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            o_done      <= (state_d == DONE);
            o_mem_req   <= (state_d == BUSY);
            o_mem_we    <= we_d;
            o_err       <= err_d;
            o_mem_be    <= be_d;
            o_rdata     <= rdata_d;
            o_mem_addr  <= addr_d;
            o_mem_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a reference model queues expected results per
// access and each scenario task compares them against what the DUT produced.
module tb_lsu_ctrl;

    localparam int unsigned TO = 4;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;

    logic        i_clk, i_rst, i_valid, i_mem_ack;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata, i_mem_rdata;
    logic        o_stall, o_done, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [1:0]  o_err;
    logic [3:0]  o_mem_be;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_opcode(i_opcode),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          req_n;
        int          stall_n;
        int          lat;
        bit          stable;
        bit          done2;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        obs_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rdata = 32'd0;

    function automatic rec_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] word, input int ack_delay);
        rec_t        e;
        bit          ld, legal, mis;
        int          off;
        logic [31:0] b, h;
        ld    = (op == OP_LD);
        off   = int'(addr[1:0]);
        legal = ld ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                   : (f3 inside {3'b000, 3'b001, 3'b010});
        mis   = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        e.we = !ld; e.addr = addr & 32'hFFFF_FFFC; e.be = 4'h0; e.wdata = 32'd0;
        e.stable = 1'b1; e.done2 = 1'b0;
        if (!ld) begin
            case (f3[1:0])
                2'b00:   begin e.be = 4'(1 << off); e.wdata = {4{wd[7:0]}}; end
                2'b01:   begin e.be = 4'(3 << off); e.wdata = {2{wd[15:0]}}; end
                default: begin e.be = 4'hF; e.wdata = wd; end
            endcase
        end
        if (!legal) begin
            e.err = 2'b11; e.req_n = 0; e.lat = 1;
        end else if (mis) begin
            e.err = 2'b01; e.req_n = 0; e.lat = 1;
        end else if (ack_delay < 1 || ack_delay > int'(TO)) begin
            e.err = 2'b10; e.req_n = int'(TO); e.lat = int'(TO) + 1;
        end else begin
            e.err = 2'b00; e.req_n = ack_delay; e.lat = ack_delay + 1;
            if (ld) begin
                b = (word >> (8 * off)) & 32'hFF;
                h = (word >> (16 * (off / 2))) & 32'hFFFF;
                case (f3)
                    3'b000:  model_rdata = b[7]  ? (b | 32'hFFFF_FF00) : b;
                    3'b100:  model_rdata = b;
                    3'b001:  model_rdata = h[15] ? (h | 32'hFFFF_0000) : h;
                    3'b101:  model_rdata = h;
                    default: model_rdata = word;
                endcase
            end
        end
        e.stall_n = e.lat;
        e.rdata   = model_rdata;
        return e;
    endfunction

    // Drives one instruction, answers the bus after ack_delay request cycles, records what happened
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int ack_delay,
                          input bit scramble);
        rec_t o;
        int   req_n;
        bit   got;
        exp_q.push_back(model(op, f3, addr, wd, word, ack_delay));
        @(negedge i_clk);
        i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        i_mem_rdata = word; i_mem_ack = 1'b0;
        o.err = 2'b00; o.rdata = 32'd0; o.we = 1'b0; o.be = 4'h0; o.addr = 32'd0;
        o.wdata = 32'd0; o.req_n = 0; o.stall_n = 0; o.lat = -1; o.stable = 1'b1; o.done2 = 1'b0;
        req_n = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (o_stall) o.stall_n++;
            if (o_done) begin
                got = 1'b1; o.err = o_err; o.rdata = o_rdata; o.lat = c; o.req_n = req_n;
                i_valid = 1'b0; i_mem_ack = 1'b0;
            end else begin
                if (o_mem_req) begin
                    req_n++;
                    if (req_n == 1) begin
                        o.we = o_mem_we; o.be = o_mem_be; o.addr = o_mem_addr; o.wdata = o_mem_wdata;
                    end else if (o.we !== o_mem_we || o.be !== o_mem_be ||
                                 o.addr !== o_mem_addr || o.wdata !== o_mem_wdata) begin
                        o.stable = 1'b0;
                    end
                    if (scramble) begin i_addr = $urandom; i_wdata = $urandom; end
                end
                i_mem_ack = o_mem_req && (req_n == ack_delay);
                @(negedge i_clk);
            end
        end
        i_valid = 1'b0; i_mem_ack = 1'b0;
        @(negedge i_clk); #1;
        o.done2 = o_done;
        obs_q.push_back(o);
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_valid = 1'b0; i_opcode = 7'd0; i_funct3 = 3'd0; i_addr = 32'd0;
        i_wdata = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if ({o_stall, o_done, o_mem_req, o_mem_we} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ctrl got %b want 0000", {o_stall, o_done, o_mem_req, o_mem_we});
        end
        n_checks++;
        if ({o_err, o_mem_be} !== 6'd0) begin
            n_errors++; $display("FAIL reset_err_be got %b want 000000", {o_err, o_mem_be});
        end
        n_checks++;
        if ({o_rdata, o_mem_addr, o_mem_wdata} !== 96'd0) begin
            n_errors++; $display("FAIL reset_data got %h %h %h want 0", o_rdata, o_mem_addr, o_mem_wdata);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_loads;
        rec_t e, o;
        run_op(OP_LD, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 2, 1'b0);
        run_op(OP_LD, 3'b101, 32'h0000_0042, 32'd0, 32'h8001_0000, 1, 1'b0);
        run_op(OP_LD, 3'b001, 32'h0000_0000, 32'd0, 32'h1234_F00D, 3, 1'b1);
        run_op(OP_LD, 3'b100, 32'h0000_0101, 32'd0, 32'h0000_9A00, 1, 1'b0);
        run_op(OP_LD, 3'b010, 32'h0000_0044, 32'd0, 32'hDEAD_BEEF, 2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.lat !== e.lat) begin n_errors++; $display("FAIL load%0d_latency got %0d want %0d", i, o.lat, e.lat); end
            n_checks++;
            if (o.rdata !== e.rdata) begin n_errors++; $display("FAIL load%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            n_checks++;
            if (o.err !== e.err) begin n_errors++; $display("FAIL load%0d_err got %b want %b", i, o.err, e.err); end
            n_checks++;
            if (o.stall_n !== e.stall_n || o.req_n !== e.req_n) begin
                n_errors++; $display("FAIL load%0d_cycles got stall %0d req %0d want %0d %0d", i, o.stall_n, o.req_n, e.stall_n, e.req_n);
            end
            n_checks++;
            if ({o.we, o.be, o.addr} !== {e.we, e.be, e.addr}) begin
                n_errors++; $display("FAIL load%0d_bus got we %b be %b addr %h want %b %b %h", i, o.we, o.be, o.addr, e.we, e.be, e.addr);
            end
            n_checks++;
            if (o.stable !== 1'b1 || o.done2 !== 1'b0) begin
                n_errors++; $display("FAIL load%0d_hold got stable %b done2 %b want 1 0", i, o.stable, o.done2);
            end
        end
    endtask

    task automatic test_stores;
        rec_t e, o;
        run_op(OP_ST, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 32'd0, 1, 1'b0);
        run_op(OP_ST, 3'b000, 32'h0000_0011, 32'h1234_565A, 32'd0, 2, 1'b1);
        run_op(OP_ST, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 32'h5555_5555, 3, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if ({o.we, o.be, o.addr, o.wdata} !== {e.we, e.be, e.addr, e.wdata}) begin
                n_errors++; $display("FAIL store%0d_bus got we %b be %b addr %h wdata %h want %b %b %h %h",
                                     i, o.we, o.be, o.addr, o.wdata, e.we, e.be, e.addr, e.wdata);
            end
            n_checks++;
            if (o.rdata !== e.rdata || o.err !== e.err) begin
                n_errors++; $display("FAIL store%0d_result got rdata %h err %b want %h %b", i, o.rdata, o.err, e.rdata, e.err);
            end
            n_checks++;
            if (o.lat !== e.lat || o.stable !== 1'b1) begin
                n_errors++; $display("FAIL store%0d_timing got lat %0d stable %b want %0d 1", i, o.lat, o.stable, e.lat);
            end
        end
    endtask

    task automatic test_faults;
        rec_t e, o;
        run_op(OP_LD, 3'b010, 32'h0000_0041, 32'd0, 32'h1111_1111, 1, 1'b0);
        run_op(OP_ST, 3'b001, 32'h0000_0023, 32'h0000_7777, 32'd0, 1, 1'b0);
        run_op(OP_LD, 3'b011, 32'h0000_0040, 32'd0, 32'h2222_2222, 1, 1'b0);
        run_op(OP_ST, 3'b100, 32'h0000_0040, 32'h3333_3333, 32'd0, 1, 1'b0);
        run_op(OP_LD, 3'b110, 32'h0000_0003, 32'd0, 32'h4444_4444, 1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.err !== e.err) begin n_errors++; $display("FAIL fault%0d_err got %b want %b", i, o.err, e.err); end
            n_checks++;
            if (o.req_n !== 0 || o.lat !== e.lat || o.stall_n !== e.stall_n) begin
                n_errors++; $display("FAIL fault%0d_timing got req %0d lat %0d stall %0d want 0 %0d %0d", i, o.req_n, o.lat, o.stall_n, e.lat, e.stall_n);
            end
            n_checks++;
            if (o.rdata !== e.rdata) begin n_errors++; $display("FAIL fault%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_timeout;
        rec_t e, o;
        run_op(OP_LD, 3'b010, 32'h0000_0080, 32'd0, 32'h0BAD_CAFE, 0, 1'b0);
        run_op(OP_LD, 3'b010, 32'h0000_0084, 32'd0, 32'h600D_F00D, int'(TO), 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.err !== e.err) begin n_errors++; $display("FAIL timeout%0d_err got %b want %b", i, o.err, e.err); end
            n_checks++;
            if (o.req_n !== e.req_n || o.lat !== e.lat) begin
                n_errors++; $display("FAIL timeout%0d_cycles got req %0d lat %0d want %0d %0d", i, o.req_n, o.lat, e.req_n, e.lat);
            end
            n_checks++;
            if (o.rdata !== e.rdata) begin n_errors++; $display("FAIL timeout%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_non_mem;
        int bad;
        @(negedge i_clk);
        i_valid = 1'b1; i_opcode = OP_R; i_funct3 = 3'b000; i_addr = 32'h0000_0041;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (o_stall || o_done || o_mem_req) bad++;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL non_mem_ignored got %0d active cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_op;
        rec_t e, o;
        int   bad;
        bit   seen;
        @(negedge i_clk);
        i_valid = 1'b1; i_opcode = OP_LD; i_funct3 = 3'b010; i_addr = 32'h0000_0050;
        i_mem_rdata = 32'h7777_8888; i_mem_ack = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge i_clk); #1;
            seen = o_mem_req;
        end
        n_checks++;
        if (seen !== 1'b1) begin n_errors++; $display("FAIL midrst_req_seen got %b want 1", seen); end
        i_rst = 1'b1;
        #1;
        n_checks++;
        if ({o_mem_req, o_stall} !== 2'b00) begin
            n_errors++; $display("FAIL midrst_async got req %b stall %b want 0 0", o_mem_req, o_stall);
        end
        n_checks++;
        if (o_rdata !== 32'd0) begin n_errors++; $display("FAIL midrst_rdata got %h want 0", o_rdata); end
        model_rdata = 32'd0;
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0; i_mem_ack = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk); #1;
            if (o_done || o_mem_req || o_stall) bad++;
        end
        i_mem_ack = 1'b0;
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL midrst_stray_ack got %0d active cycles want 0", bad); end
        run_op(OP_ST, 3'b010, 32'h0000_0060, 32'hA5A5_0F0F, 32'd0, 1, 1'b0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if ({o.err, o.we, o.be, o.addr, o.wdata} !== {e.err, e.we, e.be, e.addr, e.wdata}) begin
            n_errors++; $display("FAIL midrst_sw got err %b we %b be %b addr %h wdata %h want %b %b %b %h %h",
                                 o.err, o.we, o.be, o.addr, o.wdata, e.err, e.we, e.be, e.addr, e.wdata);
        end
        n_checks++;
        if (o.lat !== e.lat || o.rdata !== e.rdata) begin
            n_errors++; $display("FAIL midrst_sw_timing got lat %0d rdata %h want %0d %h", o.lat, o.rdata, e.lat, e.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_timeout();
        test_non_mem();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
